// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 4-digit 7-segment scan driver.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low, so a 0 bit
// lights the corresponding segment on the common-anode display.
package seg7_pkg;

  // Number of multiplexed digits on the board.
  localparam int NUM_DIGITS = 4;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex glyphs, active-low {g,f,e,d,c,b,a}; b and d are lowercase so they
  // cannot be confused with 8 and 0.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Index of the digit currently being scanned (0 = rightmost).
  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/hex7seg.sv
// hex7seg: purely combinational nibble to active-low 7-segment decoder.
// Output order is {g,f,e,d,c,b,a}.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Map each hex value onto its glyph from the package table.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan4.sv
// seg7_scan4: time-multiplexed 4-digit hex display driver for a common-anode
// 7-segment display. Each digit owns a slot of REFRESH_DIV clocks; the first
// BLANK_CYC clocks of every slot keep all anodes off to avoid ghosting. The
// displayed count is captured once per full scan so all digits agree.
//
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN - blank segments of leading-zero digits above
//   the most significant non-zero nibble (digit 0 is always shown). Blanked
//   digits still drive their anode and decimal point.
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        scan_done
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);
  localparam digit_idx_t       LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div;
  digit_idx_t       idx;
  logic [15:0]      snap;
  logic             first;

  logic             div_wrap;
  logic             scan_wrap;
  logic [3:0]       cur_nibble;
  logic [6:0]       dec_seg;
  logic             lead_blank;

  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  assign div_wrap  = (div == DIV_LAST);
  assign scan_wrap = div_wrap && (idx == LAST_DIGIT);

  // Slot divider, digit index and snapshot; everything freezes while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      idx   <= '0;
      snap  <= '0;
      first <= 1'b1;
    end else if (en) begin
      if (div_wrap) begin
        div <= '0;
        idx <= idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
      if (first) begin
        snap  <= value;
        first <= 1'b0;
      end else if (scan_wrap) begin
        snap <= value;
      end
    end
  end

  // One-cycle pulse for every end-of-scan reload; the initial load is silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_done <= 1'b0;
    end else begin
      scan_done <= en && !first && scan_wrap;
    end
  end

  // Select the nibble belonging to the digit currently being scanned.
  always_comb begin
    cur_nibble = snap[{idx, 2'b00} +: 4];
  end

  hex7seg u_hex7seg (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Blank a digit when it and every nibble above it are zero; digit 0 never blanks.
  always_comb begin
    lead_blank = 1'b0;
    case (idx)
      2'd3:    lead_blank = (snap[15:12] == 4'h0);
      2'd2:    lead_blank = (snap[15:8]  == 8'h00);
      2'd1:    lead_blank = (snap[15:4]  == 12'h000);
      default: lead_blank = 1'b0;
    endcase
  end
`else
  // Every digit is always shown, leading zeros included.
  always_comb begin
    lead_blank = 1'b0;
  end
`endif

  // Next display drive: dark during the slot's blanking window or when disabled.
  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (en && (div >= BLANK_LIM)) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = lead_blank ? SEG_BLANK : dec_seg;
      dp_nxt  = ~dp_in[idx];
    end
  end

  // Register the pin drive so the display sees glitch-free outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan4.sv
// tb_seg7_scan4: self-checking bench for seg7_scan4 with REFRESH_DIV=8 and
// BLANK_CYC=2. Follows SEG7_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg7_scan4;

  localparam int RD = 8;
  localparam int BL = 2;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        scan_done;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  seg7_scan4 #(.REFRESH_DIV(RD), .BLANK_CYC(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .value     (value),
    .dp_in     (dp_in),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Turn a list of lit segment letters into an active-low {g..a} vector.
  function automatic logic [6:0] litToSeg(input string s);
    logic [6:0] r;
    int k;
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s[i]) - 97;
      if (k >= 0 && k < 7) r[k] = 1'b0;
    end
    return r;
  endfunction

  // Glyph for a display character; a space is a dark digit.
  function automatic logic [6:0] charToSeg(input logic [7:0] c);
    case (c)
      "0": return litToSeg("abcdef");
      "1": return litToSeg("bc");
      "2": return litToSeg("abdeg");
      "3": return litToSeg("abcdg");
      "4": return litToSeg("bcfg");
      "5": return litToSeg("acdfg");
      "6": return litToSeg("acdefg");
      "7": return litToSeg("abc");
      "8": return litToSeg("abcdefg");
      "9": return litToSeg("abcdfg");
      "A": return litToSeg("abcefg");
      "B": return litToSeg("cdefg");
      "C": return litToSeg("adef");
      "D": return litToSeg("bcdeg");
      "E": return litToSeg("adefg");
      "F": return litToSeg("aefg");
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] nibbleSeg(input int n);
    string hexchars;
    hexchars = "0123456789ABCDEF";
    return charToSeg(hexchars[n]);
  endfunction

  // Reference model: position is a plain count of enabled clocks since reset.
  int          en_cycles;
  logic [15:0] m_snap;
  bit          m_first;
  int          m_div, m_idx, m_upper;
  bit          m_active, m_blank, m_last;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_done;

  always_comb begin
    m_div    = en_cycles % RD;
    m_idx    = (en_cycles / RD) % 4;
    m_upper  = int'(m_snap) >> (4 * m_idx);
    m_active = en && (m_div >= BL);
    m_blank  = LZB && (m_idx > 0) && (m_upper == 0);
    m_last   = (m_div == RD - 1) && (m_idx == 3);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_cycles <= 0;
      m_snap    <= 16'h0;
      m_first   <= 1'b1;
      exp_an    <= 4'hF;
      exp_seg   <= 7'h7F;
      exp_dp    <= 1'b1;
      exp_done  <= 1'b0;
    end else begin
      exp_an   <= m_active ? ~(4'b0001 << m_idx) : 4'hF;
      exp_seg  <= !m_active ? 7'h7F : (m_blank ? 7'h7F : nibbleSeg(m_upper % 16));
      exp_dp   <= m_active ? ~dp_in[m_idx] : 1'b1;
      exp_done <= en && !m_first && m_last;
      if (en) begin
        en_cycles <= en_cycles + 1;
        if (m_first || m_last) m_snap <= value;
        m_first <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic e);
    value = v;
    dp_in = d;
    en    = e;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    en    = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Scoreboard comparison every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("sb_an", {12'h0, an}, {12'h0, exp_an});
      checkOutput("sb_seg", {9'h0, seg}, {9'h0, exp_seg});
      checkOutput("sb_dp", {15'h0, dp}, {15'h0, exp_dp});
      checkOutput("sb_scan_done", {15'h0, scan_done}, {15'h0, exp_done});
    end
  end

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [31:0] chars_plain;
    logic [31:0] chars_lzb;
  } vector_t;

  vector_t vecs[7];

  initial begin
    int pulses;
    int d;
    logic [31:0] chars;
    logic [15:0] mask;

    vecs[0] = '{16'h12AF, 4'b0000, "12AF", "12AF"};
    vecs[1] = '{16'h00A5, 4'b0000, "00A5", "  A5"};
    vecs[2] = '{16'h0000, 4'b0001, "0000", "   0"};
    vecs[3] = '{16'h3C0D, 4'b1010, "3C0D", "3C0D"};
    vecs[4] = '{16'h0B70, 4'b0100, "0B70", " B70"};
    vecs[5] = '{16'h9E64, 4'b1111, "9E64", "9E64"};
    vecs[6] = '{16'h0008, 4'b1000, "0008", "   8"};

    rst_n = 1'b0;
    applyStimulus(16'h0, 4'h0, 1'b0);
    resetDut();
    chk_on = 1'b1;
    checkOutput("reset_an", {12'h0, an}, 16'h000F);
    checkOutput("reset_seg", {9'h0, seg}, 16'h007F);
    checkOutput("reset_dp", {15'h0, dp}, 16'h0001);
    checkOutput("reset_scan_done", {15'h0, scan_done}, 16'h0000);

    // Table vectors: one full scan each from reset.
    for (int v = 0; v < 7; v++) begin
      resetDut();
      applyStimulus(vecs[v].value, vecs[v].dp_in, 1'b1);
      chars = LZB ? vecs[v].chars_lzb : vecs[v].chars_plain;
      for (int k = 0; k < 4 * RD; k++) begin
        tick(1);
        d = k / RD;
        if (k % RD < BL) checkOutput("tbl_blank_an", {12'h0, an}, 16'h000F);
        if (k % RD == 4) begin
          checkOutput("tbl_an", {12'h0, an}, {12'h0, ~(4'b0001 << d)});
          checkOutput("tbl_seg", {9'h0, seg}, {9'h0, charToSeg(chars[8*d +: 8])});
          checkOutput("tbl_dp", {15'h0, dp}, {15'h0, ~vecs[v].dp_in[d]});
        end
      end
    end

    // Value change in slot 1 is held off until the end-of-scan reload.
    resetDut();
    applyStimulus(16'h12AF, 4'h0, 1'b1);
    tick(13);
    checkOutput("chg_slot1", {9'h0, seg}, {9'h0, charToSeg("A")});
    applyStimulus(16'h0000, 4'h0, 1'b1);
    pulses = 0;
    for (int k = 13; k <= 44; k++) begin
      tick(1);
      if (scan_done) pulses++;
      if (k == 20) checkOutput("chg_slot2_old", {9'h0, seg}, {9'h0, charToSeg("2")});
      if (k == 28) checkOutput("chg_slot3_old", {9'h0, seg}, {9'h0, charToSeg("1")});
      if (k == 36) checkOutput("chg_new_d0", {9'h0, seg}, {9'h0, charToSeg("0")});
      if (k == 44) checkOutput("chg_new_d1", {9'h0, seg}, {9'h0, LZB ? 7'h7F : charToSeg("0")});
    end
    checkOutput("chg_done_pulses", pulses[15:0], 16'd1);

    // Freeze in slot 2 for 20 cycles, then resume at the same divider count.
    resetDut();
    applyStimulus(16'h12AF, 4'h0, 1'b1);
    tick(20);
    applyStimulus(16'h12AF, 4'h0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      checkOutput("freeze_an", {12'h0, an}, 16'h000F);
    end
    applyStimulus(16'h12AF, 4'h0, 1'b1);
    tick(1);
    checkOutput("resume_an", {12'h0, an}, 16'h000B);
    checkOutput("resume_seg", {9'h0, seg}, {9'h0, charToSeg("2")});
    tick(3);
    checkOutput("resume_slot_end_an", {12'h0, an}, 16'h000B);
    tick(1);
    checkOutput("resume_next_blank", {12'h0, an}, 16'h000F);

    // Decimal point only on digit 2.
    resetDut();
    applyStimulus(16'h12AF, 4'b0100, 1'b1);
    for (int k = 0; k < 4 * RD; k++) begin
      tick(1);
      checkOutput("dp_digit2", {15'h0, dp}, {15'h0, !((k / RD == 2) && (k % RD >= BL))});
    end

    // Asynchronous reset mid-slot, then a silent first load.
    applyStimulus(16'h4321, 4'h0, 1'b1);
    tick(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_an", {12'h0, an}, 16'h000F);
    checkOutput("async_seg", {9'h0, seg}, 16'h007F);
    checkOutput("async_dp", {15'h0, dp}, 16'h0001);
    tick(1);
    rst_n = 1'b1;
    for (int k = 0; k < 4 * RD; k++) begin
      tick(1);
      checkOutput("post_reset_done", {15'h0, scan_done}, {15'h0, k == 4 * RD - 1});
      if (k == 4) checkOutput("post_reset_d0", {9'h0, seg}, {9'h0, charToSeg("1")});
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      tick(1);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 16'hFFFF;
          1: mask = 16'h0FFF;
          2: mask = 16'h00FF;
          default: mask = 16'h000F;
        endcase
        value = 16'($urandom) & mask;
      end
      if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
      en = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
    end

    tick(1);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
